// File: rtl/multi_pulse_sync.sv
// Multi-channel pulse synchroniser from clka to clkb with a toggle/acknowledge
// return path, so each channel reports busy until its pulse has been delivered.
module multi_pulse_sync #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clka,
  input  logic           clkb,
  input  logic           rst_n,
  input  logic [NCH-1:0] din,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] drop,
  input  logic [NCH-1:0] drop_clr,
  output logic [NCH-1:0] dout
);

  // Per-channel state is the phase difference between request and returned ack.
  typedef enum logic {
    IDLE     = 1'b0,
    INFLIGHT = 1'b1
  } chan_state_e;

  chan_state_e state [NCH];

  logic [NCH-1:0] req_t;
  logic [NCH-1:0] ack_s;
  logic [NCH-1:0] ack_t;
  logic [NCH-1:0] accept;
  logic [NCH-1:0] overlap;

  (* async_reg = "true" *) logic [SYNC_STAGES-1:0][NCH-1:0] ack_sync;
  (* async_reg = "true" *) logic [SYNC_STAGES-1:0][NCH-1:0] req_sync;

  assign ack_s = ack_sync[SYNC_STAGES-1];

  // busy depends on flops only, so a din arriving as busy falls is accepted.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state[i] = IDLE;
      if (req_t[i] ^ ack_s[i]) state[i] = INFLIGHT;
      busy[i] = (state[i] == INFLIGHT);
    end
  end

  assign accept  = din & ~busy;
  assign overlap = din & busy;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      req_t    <= '0;
      ack_sync <= '0;
      drop     <= '0;
    end else begin
      req_t    <= req_t ^ accept;
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_t};
      // A new overlap takes priority over a same-cycle clear.
      drop     <= (drop & ~drop_clr) | overlap;
    end
  end

  // Destination side: ack_t is the history flop that turns toggles into pulses.
  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      req_sync <= '0;
      ack_t    <= '0;
      dout     <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_t};
      ack_t    <= req_sync[SYNC_STAGES-1];
      dout     <= req_sync[SYNC_STAGES-1] ^ ack_t;
    end
  end

endmodule

// File: tb/tb_multi_pulse_sync.sv
// Randomised bench for multi_pulse_sync: timing-window reference model,
// per-channel expected-pulse queues and a dout monitor in the clkb domain.
module tb_multi_pulse_sync;

  localparam int NCH = 4;
  localparam int SS  = 2;

  logic           clka = 1'b0;
  logic           clkb = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] din;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] drop;
  logic [NCH-1:0] drop_clr;
  logic [NCH-1:0] dout;

  int     half_a = 5000;
  int     half_b = 13514;
  longint pa     = 10000;
  longint pb     = 27028;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a channel is surely busy before lo_t and surely idle from hi_t.
  logic           accepted [NCH];
  longint         lo_t     [NCH];
  longint         hi_t     [NCH];
  logic [NCH-1:0] mdrop;
  logic [63:0]    exp_q    [NCH][$];
  longint         last_pos = 0;

  multi_pulse_sync #(.NCH(NCH), .SYNC_STAGES(SS)) dut (
    .clka     (clka),
    .clkb     (clkb),
    .rst_n    (rst_n),
    .din      (din),
    .busy     (busy),
    .drop     (drop),
    .drop_clr (drop_clr),
    .dout     (dout)
  );

  // ---------------- clock / reset ----------------
  initial forever #(half_a) clka = ~clka;
  initial forever #(half_b) clkb = ~clkb;

  always @(posedge clka) last_pos <= longint'($time);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit idle_def(input int ch, input longint t);
    return !accepted[ch] || (t >= hi_t[ch]);
  endfunction

  function automatic bit busy_def(input int ch, input longint t);
    return accepted[ch] && (t < lo_t[ch]);
  endfunction

  function automatic bit all_idle(input longint t);
    for (int ch = 0; ch < NCH; ch++)
      if (!idle_def(ch, t)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    mdrop = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      accepted[ch] = 1'b0;
      lo_t[ch]     = 0;
      hi_t[ch]     = 0;
      exp_q[ch].delete();
    end
  endtask

  // Apply the edge that just sampled d/c to the model.
  task automatic model_edge(input logic [NCH-1:0] d, input logic [NCH-1:0] c);
    longint         now;
    logic [NCH-1:0] set;
    now = longint'($time);
    set = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (d[ch]) begin
        if (idle_def(ch, now)) begin
          accepted[ch] = 1'b1;
          lo_t[ch]     = now + SS * pb + (SS - 1) * pa;
          hi_t[ch]     = now + (SS + 2) * pb + (SS + 2) * pa;
          exp_q[ch].push_back(64'(now + (SS + 2) * pb + pb / 2 + 1));
        end else begin
          set[ch] = 1'b1;
        end
      end
    end
    mdrop = (mdrop & ~c) | set;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic [NCH-1:0] d, input logic [NCH-1:0] c);
    din      = d;
    drop_clr = c;
    @(posedge clka);
    model_edge(d, c);
    #1;
    din      = '0;
    drop_clr = '0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 2000 && !all_idle(longint'($time) - 1 + pa)) begin
      drive_cycle('0, '0);
      k++;
    end
  endtask

  task automatic set_clocks(input int ha, input int hb);
    half_a = ha;
    half_b = hb;
    pa     = 2 * ha;
    pb     = 2 * hb;
    repeat (4) drive_cycle('0, '0);
  endtask

  task automatic random_run(input int n);
    logic [NCH-1:0] d;
    logic [NCH-1:0] c;
    longint         tn;
    repeat (n) begin
      d  = '0;
      tn = longint'($time) - 1 + pa;
      for (int ch = 0; ch < NCH; ch++) begin
        if (idle_def(ch, tn) && $urandom_range(0, 3) == 0) d[ch] = 1'b1;
        else if (busy_def(ch, tn) && $urandom_range(0, 4) == 0) d[ch] = 1'b1;
      end
      c = '0;
      if ($urandom_range(0, 7) == 0) c[$urandom_range(0, NCH - 1)] = 1'b1;
      drive_cycle(d, c);
    end
    wait_idle();
  endtask

  task automatic paced_stream(input int ch, input int n);
    logic [NCH-1:0] d;
    d     = '0;
    d[ch] = 1'b1;
    repeat (n) begin
      wait_idle();
      drive_cycle(d, '0);
    end
    wait_idle();
    check($sformatf("paced_drop_ch%0d", ch), drop[ch], 0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clkb) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (dout[ch] === 1'b1) begin
        if (exp_q[ch].size() == 0) begin
          check($sformatf("dout_unexpected_ch%0d", ch), 1, 0);
        end else begin
          logic [63:0] dl;
          dl = exp_q[ch].pop_front();
          check($sformatf("dout_in_time_ch%0d", ch), longint'($time <= dl), 1);
        end
      end
    end
  end

  always @(negedge clka) begin
    check("drop", longint'(drop), longint'(mdrop));
    for (int ch = 0; ch < NCH; ch++) begin
      if (busy_def(ch, last_pos))
        check($sformatf("busy_high_ch%0d", ch), busy[ch], 1);
      else if (idle_def(ch, last_pos))
        check($sformatf("busy_low_ch%0d", ch), busy[ch], 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    din      = '0;
    drop_clr = '0;
    model_reset();
    #3000;
    check("reset_busy", longint'(busy), 0);
    check("reset_drop", longint'(drop), 0);
    check("reset_dout", longint'(dout), 0);
    #20003;
    rst_n = 1'b1;
    drive_cycle('0, '0);

    // clka 100 MHz, clkb ~37 MHz
    drive_cycle(4'b0001, '0);
    wait_idle();

    drive_cycle(4'b0010, '0);
    drive_cycle('0, '0);
    drive_cycle(4'b0010, '0);
    check("b2b_drop1_set", drop[1], 1);
    drive_cycle('0, 4'b0010);
    check("b2b_drop1_clr", drop[1], 0);
    wait_idle();

    drive_cycle(4'b1111, '0);
    wait_idle();
    check("simul_busy_clear", longint'(busy), 0);

    drive_cycle('0, 4'b1000);
    drive_cycle(4'b1000, '0);
    drive_cycle(4'b1000, 4'b1000);
    check("collision_drop3", drop[3], 1);
    drive_cycle('0, 4'b1000);
    wait_idle();

    drive_cycle(4'b0100, '0);
    drive_cycle(4'b0100, '0);
    drive_cycle(4'b0100, '0);
    check("held_din_drop2", drop[2], 1);
    drive_cycle('0, 4'b0100);
    wait_idle();

    paced_stream(2, 20);
    random_run(300);

    // Reset while a pulse is still crossing.
    drive_cycle(4'b0001, '0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clka);
    #1;
    rst_n = 1'b1;
    repeat (30) drive_cycle('0, '0);
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_drop", longint'(drop), 0);

    // clka ~37 MHz, clkb 100 MHz
    set_clocks(13514, 5000);
    paced_stream(2, 20);
    drive_cycle(4'b1111, '0);
    wait_idle();
    random_run(300);

    repeat (5) drive_cycle('0, '0);
    for (int ch = 0; ch < NCH; ch++)
      check($sformatf("all_delivered_ch%0d", ch), longint'(exp_q[ch].size()), 0);
    check("final_busy", longint'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_pulse_sync.md
# multi_pulse_sync

Parametrised multi-channel pulse synchroniser with a return-acknowledge handshake. It carries NCH independent single-cycle pulses from the clka domain to the clkb domain. Each channel reports busy back to the source until its pulse has been delivered, so pulses are never silently merged. Overlapping requests are dropped and flagged. It is the standard crossing for event, strobe and interrupt signals between unrelated clock domains.

## Interface
- NCH, 4, number of independent channels (1..32)
- SYNC_STAGES, 2, synchroniser flops per crossing direction (2..4)
- clka  input  1  source clock
- clkb  input  1  destination clock, asynchronous to clka
- rst_n  input  1  reset, asynchronous, active-low; clock clka; the same net also asynchronously resets all clkb-domain flops
- din  input  NCH  per-channel request pulse, sampled on posedge clka
- busy  output  NCH  clka domain; 1 = channel has a pulse in flight
- drop  output  NCH  clka domain; sticky, set when din arrives while busy
- drop_clr  input  NCH  clka domain; per-channel clear for drop
- dout  output  NCH  clkb domain; one-clkb-cycle pulse per delivered request

## Operation
Per channel, all channels are identical and fully independent:
- Source (clka): request toggle req_t.
  - din=1 && busy=0: req_t flips.
  - din=1 && busy=1: req_t holds and drop is set.
  - Otherwise req_t holds.
- Forward crossing: req_t passes through SYNC_STAGES clkb flops, then one history flop ack_t.
  - dout <= last_stage ^ ack_t (registered).
  - ack_t <= last_stage.
- Return crossing: ack_t passes through SYNC_STAGES clka flops to ack_s.
  - busy = req_t ^ ack_s (XOR of flops only, no input in the path).
- Channel states, decoded from (req_t ^ ack_s):
  - IDLE: busy=0.
  - INFLIGHT: busy=1, from the accepting edge until ack_s matches req_t.
- drop:
  - Set on the clka edge where din=1 && busy=1.
  - Cleared by drop_clr=1.
  - Simultaneous set and clear: set wins.
- din is a pulse qualifier. A din held high for N clka cycles while the channel is IDLE is accepted once, then drops on the later cycles (busy is already 1). drop goes high as soon as a subsequent cycle sees busy=1.
- din in the same cycle busy deasserts is accepted, because busy is registered-derived and already 0.
- Reset values (rst_n=0, asynchronous):
  - req_t, all sync flops, ack_t, ack_s: 0.
  - busy, drop, dout: 0.
- Reset mid-flight: all in-flight pulses are discarded, no dout is emitted after release, and every channel returns to IDLE.
- rst_n deassertion must be synchronised externally in each domain. The block does not re-synchronise it.

## Timing
- Forward latency: din accepted at clka edge k flips req_t at k. dout rises after clkb edge SYNC_STAGES+1 following the first clkb edge that samples the new req_t. Width is exactly 1 clkb cycle.
- busy rises in the clka cycle after the accepting edge (same edge as the req_t flip).
- Round trip: busy falls no later than (SYNC_STAGES+2) clkb periods + (SYNC_STAGES+1) clka periods after acceptance.
- Maximum accepted rate per channel: one pulse per round trip. Any clka/clkb ratio is supported, with no frequency constraint.
- Flop fan-out: only one bit per channel crosses in each direction, so there are no multi-bit CDC paths.
- Synchroniser flops carry the async_reg attribute.

## Test plan
- Single pulse, NCH=4, SYNC_STAGES=2, clka 100 MHz, clkb 37 MHz; din=4'b0001 for 1 cycle -> dout[0] one clkb cycle high 3 clkb edges after sampling. busy[0] is high from the next clka edge until round trip. dout[3:1]=0. drop=0.
- Back-to-back on one channel: din[1] pulses at cycles 0 and 2, with clkb slow -> exactly one dout[1] pulse. drop[1]=1 after cycle 2. drop_clr[1]=1 -> drop[1]=0 on the next edge.
- Paced stream: 20 pulses on din[2], each issued only when busy[2]=0, clka 37 MHz / clkb 100 MHz and the reverse -> exactly 20 dout[2] pulses and drop[2]=0.
- Simultaneous channels: din=4'b1111 in one cycle -> each dout bit pulses once (same clkb cycle is allowed). All busy bits clear, and there is no cross-channel interference.
- Reset mid-flight: din[0] pulse, then rst_n=0 for 2 clka cycles before dout fires -> no dout[0] after release, and busy=drop=0.
- Set/clear collision: drop[3]=0, din[3]=1 while busy[3]=1 and drop_clr[3]=1 on the same edge -> drop[3]=1.
